// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath buffers: the read-phase encoding and
// the pointer-width derivation used by the result FIFO and the operand FIFOs.
package alu_pkg;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // One extra MSB above the address bits lets full and empty be told apart.
    function automatic int ptr_size(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mul_res_fifo_if.sv
// Handshake bundle between the multiplier, the result buffer and the consumer.
// slave = the buffer itself, master = whoever drives products and accepts halves.
interface mul_res_fifo_if
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 4,
    parameter int PTR_SIZE  = ptr_size(DEPTH)
) ();

    logic [2*DATA_SIZE-1:0] res_in;
    logic                   valid_in;
    logic                   ready_out;
    logic [DATA_SIZE-1:0]   data_out;
    logic                   half_out;
    logic                   valid_out;
    logic                   ready_in;
    logic [PTR_SIZE-1:0]    count;

    modport slave (
        input  res_in, valid_in, ready_in,
        output ready_out, data_out, half_out, valid_out, count
    );

    modport master (
        output res_in, valid_in, ready_in,
        input  ready_out, data_out, half_out, valid_out, count
    );

endinterface

// File: rtl/mul_res_fifo_mem.sv
// Product storage for the result buffer: one synchronous write port and a
// combinational read port.
module res_fifo_mem #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; validity is tracked entirely by the pointers,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mul_res_fifo.sv
// Result buffer after the sequential multiplier: stores full-width products and
// hands each one to the consumer as a low half followed by a high half.
module mul_res_fifo
    import alu_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH     = 4,
    parameter int PTR_SIZE  = ptr_size(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_res_fifo_if.slave  bus
);

    localparam int ADDR_W = PTR_SIZE - 1;

    logic [PTR_SIZE-1:0]    r_wr_ptr;
    logic [PTR_SIZE-1:0]    r_rd_ptr;
    phase_e                 r_phase;
    phase_e                 w_phase_nxt;
    logic [PTR_SIZE-1:0]    w_count;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_half_pop;
    logic                   w_free;
    logic [2*DATA_SIZE-1:0] w_rd_word;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[PTR_SIZE-1] != r_rd_ptr[PTR_SIZE-1]);

    // Flags come from registered pointers only, so a pop never opens room for
    // a push in the same cycle and a push is never visible the cycle it lands.
    assign w_push     = bus.valid_in & ~w_full;
    assign w_half_pop = ~w_empty & bus.ready_in;
    assign w_free     = w_half_pop & (r_phase == PH_HIGH);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_SIZE'(1);
            end
            if (w_free) begin
                r_rd_ptr <= r_rd_ptr + PTR_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= PH_LOW;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // NOTE: the default comes first so no path through this block infers a latch.
    always_comb begin
        w_phase_nxt = r_phase;
        if (w_half_pop) begin
            w_phase_nxt = (r_phase == PH_LOW) ? PH_HIGH : PH_LOW;
        end
    end

    res_fifo_mem #(
        .WIDTH  (2 * DATA_SIZE),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (bus.res_in),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_rd_word)
    );

    always_comb begin
        bus.data_out = '0;
        if (!w_empty) begin
            bus.data_out = (r_phase == PH_HIGH) ? w_rd_word[2*DATA_SIZE-1:DATA_SIZE]
                                                : w_rd_word[DATA_SIZE-1:0];
        end
    end

    assign bus.half_out  = r_phase;
    assign bus.valid_out = ~w_empty;
    assign bus.ready_out = ~w_full;
    assign bus.count     = w_count;

endmodule

// File: tb/tb_mul_res_fifo.sv
// Randomised and directed stimulus for mul_res_fifo, scored against a queue
// model of products plus a half-select bit.
module tb_mul_res_fifo;

    localparam int DATA_SIZE = 8;
    localparam int DEPTH     = 4;
    localparam int PTR_SIZE  = $clog2(DEPTH) + 1;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_failed;

    logic [2*DATA_SIZE-1:0] q[$];
    bit                     ph;

    mul_res_fifo_if #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .PTR_SIZE(PTR_SIZE)) bus ();

    mul_res_fifo #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .PTR_SIZE(PTR_SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare outputs mid-cycle, then advance the model.
    task automatic step(input bit v, input logic [15:0] d, input bit r, output bit acc);
        logic [15:0] head;
        bit          do_push;
        bit          do_pop;
        bus.valid_in = v;
        bus.res_in   = d;
        bus.ready_in = r;
        @(negedge clk);
        head = (q.size() != 0) ? q[0] : 16'h0;
        check("count",     32'(bus.count),     32'(q.size()));
        check("valid_out", 32'(bus.valid_out), 32'(q.size() != 0));
        check("ready_out", 32'(bus.ready_out), 32'(q.size() != DEPTH));
        check("half_out",  32'(bus.half_out),  32'(ph));
        check("data_out",  32'(bus.data_out),
              (q.size() == 0) ? 32'h0 : (ph ? 32'(head[15:8]) : 32'(head[7:0])));
        @(posedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            q.delete();
            ph = 1'b0;
        end else begin
            do_push = v && (q.size() < DEPTH);
            do_pop  = r && (q.size() != 0);
            if (do_pop) begin
                if (ph) begin
                    void'(q.pop_front());
                    ph = 1'b0;
                end else begin
                    ph = 1'b1;
                end
            end
            if (do_push) q.push_back(d);
            acc = do_push;
        end
        #1;
    endtask

    initial begin
        bit acc;
        int idx;
        int cyc;

        n_tests  = 0;
        n_failed = 0;
        bus.valid_in = 1'b0;
        bus.res_in   = '0;
        bus.ready_in = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        ph    = 1'b0;
        rst_n = 1'b1;

        // Single product, low half then high half.
        step(1'b1, 16'hBEEF, 1'b0, acc);
        check("beef_lo", 32'(bus.data_out), 32'hEF);
        step(1'b0, 16'h0000, 1'b1, acc);
        check("beef_hi", 32'(bus.data_out), 32'hBE);
        step(1'b0, 16'h0000, 1'b1, acc);
        check("beef_empty", 32'(bus.valid_out), 32'h0);

        // Fill to full, drop a fifth push, drain.
        for (int i = 1; i <= 4; i++) step(1'b1, {8'(i), 8'(i)}, 1'b0, acc);
        check("full_count", 32'(bus.count), 32'(DEPTH));
        step(1'b1, 16'h0505, 1'b0, acc);
        check("drop_fifth", 32'(acc), 32'h0);
        for (int i = 0; i < 9; i++) step(1'b0, 16'h0000, 1'b1, acc);

        // Full, HIGH phase, simultaneous push and freeing pop.
        for (int i = 0; i < 4; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, acc);
        step(1'b0, 16'h0000, 1'b1, acc);
        step(1'b1, 16'hC0DE, 1'b1, acc);
        check("full_push_rej", 32'(acc), 32'h0);
        check("full_pop_count", 32'(bus.count), 32'(DEPTH - 1));
        check("full_pop_ready", 32'(bus.ready_out), 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, acc);

        // Wrap-around stream with a toggling consumer.
        idx = 0;
        cyc = 0;
        while ((idx < 10 || q.size() != 0) && cyc < 200) begin
            step(idx < 10, {8'(idx), 8'(idx)}, cyc[0], acc);
            if (acc) idx++;
            cyc++;
        end
        check("wrap_done", 32'(idx + q.size()), 32'd10);

        // Steady state: push and pop every cycle.
        for (int i = 0; i < 40; i++) step(1'b1, 16'($urandom), 1'b1, acc);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 16'($urandom), 1'($urandom), acc);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b1, acc);

        // Reset in the middle of reading a product.
        step(1'b1, 16'h1111, 1'b0, acc);
        step(1'b1, 16'h2222, 1'b0, acc);
        step(1'b0, 16'h0000, 1'b1, acc);
        check("pre_rst_half", 32'(bus.half_out), 32'h1);
        check("pre_rst_count", 32'(bus.count), 32'h2);
        rst_n = 1'b0;
        step(1'b1, 16'h7777, 1'b1, acc);
        rst_n = 1'b1;
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_valid", 32'(bus.valid_out), 32'h0);
        step(1'b1, 16'h1234, 1'b0, acc);
        check("post_rst_lo", 32'(bus.data_out), 32'h34);
        step(1'b0, 16'h0000, 1'b1, acc);
        step(1'b0, 16'h0000, 1'b1, acc);
        step(1'b0, 16'h0000, 1'b0, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
